cache_arbiter: RTL



---
 rtl/cache_arbiter_pkg.sv | 35 +++
 rtl/cache_arbiter_rr_pick.sv | 38 +++
 rtl/cache_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared definitions for the cache arbiter: FSM states, operation encoding,
// the latched request record and the combine-pair helper.
package cache_arbiter_pkg;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 10;

   // Same encoding the cache uses for its operation field.
   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'd0,
      ARB_ISSUE = 3'd1,
      ARB_ARM   = 3'd2,
      ARB_WAIT  = 3'd3,
      ARB_DONE  = 3'd4
   } arb_state_e;

   typedef struct packed {
      logic              op;
      logic              bypass;
      logic              combine;
      logic [ADDR_W-1:0] addr;
      logic [ADDR_W-1:0] raw_addr;
      logic [DATA_W-1:0] wdata;
   } arb_req_t;

   // An even-half combine write opens a pair that must be closed by the same requester.
   function automatic logic starts_pair(input arb_req_t r);
      return (r.op == OP_WRITE) && r.combine && !r.raw_addr[0];
   endfunction

endpackage

// File: rtl/cache_arbiter_rr_pick.sv
// Combinational requester selector: optional strict priority for requester 0,
// otherwise round-robin starting one past the last winner.
module cache_arbiter_rr_pick
   import cache_arbiter_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0] valid,
   input  logic [1:0]      pointer,
   input  logic            prio0,
   output logic [NREQ-1:0] onehot,
   output logic [1:0]      index,
   output logic            found
);

   logic [1:0] cand;

   always_comb begin
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      cand   = '0;
      if (prio0 && valid[0]) begin
         onehot[0] = 1'b1;
         found     = 1'b1;
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            cand = 2'((int'(pointer) + k) % NREQ);
            if (!found && valid[cand]) begin
               onehot[cand] = 1'b1;
               index        = cand;
               found        = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates NREQ requesters onto the single-ported byte cache, holds the
// winner's operation stable until the cache finishes and returns a one-cycle ack.
module cache_arbiter
   import cache_arbiter_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int PRIO0   = 1,
   parameter int TIMEOUT = 1023
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_read,
   input  logic [NREQ-1:0]        req_bypass,
   input  logic [NREQ-1:0]        req_combine,
   input  logic [ADDR_W*NREQ-1:0] req_addr,
   input  logic [ADDR_W*NREQ-1:0] req_raw_addr,
   input  logic [DATA_W*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]        req_ack,
   output logic [DATA_W-1:0]      req_rdata,
   output logic                   req_err,
   output logic [1:0]             grant_id,
   output logic                   c_enable,
   output logic                   c_read,
   output logic                   c_read_en,
   output logic                   c_write_en,
   output logic                   c_bypass,
   output logic                   c_combine,
   output logic [ADDR_W-1:0]      c_address,
   output logic [ADDR_W-1:0]      c_raw_address,
   output logic [DATA_W-1:0]      c_data_in,
   input  logic                   c_busy,
   input  logic [DATA_W-1:0]      c_data_out
);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_e       state;
   logic [1:0]       rr_ptr;
   logic [1:0]       lock_id;
   logic             lock_vld;
   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   logic [NREQ-1:0]  lock_mask;
   logic [NREQ-1:0]  grant_mask;
   logic [NREQ-1:0]  eligible;
   logic [NREQ-1:0]  pick_oh;
   logic [1:0]       pick_idx;
   logic             pick_found;
   arb_req_t         win;

   always_comb begin
      lock_mask  = '0;
      grant_mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         lock_mask[i]  = (lock_id == 2'(i));
         grant_mask[i] = (grant_id == 2'(i));
      end
   end

   // While a combine pair is open only its owner may be granted.
   assign eligible = lock_vld ? (req_valid & lock_mask) : req_valid;

   cache_arbiter_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .valid   (eligible),
      .pointer (rr_ptr),
      .prio0   ((PRIO0 != 0) && !lock_vld),
      .onehot  (pick_oh),
      .index   (pick_idx),
      .found   (pick_found)
   );

   always_comb begin
      win = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_oh[i]) begin
            win.op       = req_read[i] ? OP_READ : OP_WRITE;
            win.bypass   = req_bypass[i];
            win.combine  = req_combine[i];
            win.addr     = req_addr[ADDR_W*i +: ADDR_W];
            win.raw_addr = req_raw_addr[ADDR_W*i +: ADDR_W];
            win.wdata    = req_wdata[DATA_W*i +: DATA_W];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ARB_IDLE;
         rr_ptr        <= '0;
         lock_vld      <= 1'b0;
         lock_id       <= '0;
         wait_cnt      <= '0;
         err_q         <= 1'b0;
         req_ack       <= '0;
         req_rdata     <= '0;
         req_err       <= 1'b0;
         grant_id      <= '0;
         c_enable      <= 1'b0;
         c_read        <= 1'b0;
         c_read_en     <= 1'b0;
         c_write_en    <= 1'b0;
         c_bypass      <= 1'b0;
         c_combine     <= 1'b0;
         c_address     <= '0;
         c_raw_address <= '0;
         c_data_in     <= '0;
      end else begin
         c_enable <= 1'b0;
         req_ack  <= '0;
         req_err  <= 1'b0;
         case (state)
            // c_busy is meaningless here: the cache keeps a stale busy flag across reset.
            ARB_IDLE: begin
               if (pick_found) begin
                  grant_id      <= pick_idx;
                  c_enable      <= 1'b1;
                  c_read        <= (win.op == OP_READ);
                  c_read_en     <= (win.op == OP_READ);
                  c_write_en    <= (win.op == OP_WRITE);
                  c_bypass      <= win.bypass;
                  c_combine     <= win.combine;
                  c_address     <= win.addr;
                  c_raw_address <= win.raw_addr;
                  c_data_in     <= win.wdata;
                  err_q         <= 1'b0;
                  lock_vld      <= starts_pair(win);
                  lock_id       <= pick_idx;
                  state         <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: state <= ARB_ARM;
            ARB_ARM: begin
               if (c_busy) begin
                  state <= ARB_WAIT;
               end else begin
                  req_ack <= grant_mask;
                  state   <= ARB_DONE;
               end
            end
            ARB_WAIT: begin
               if (!c_busy) begin
                  req_rdata <= c_data_out;
                  req_ack   <= grant_mask;
                  state     <= ARB_DONE;
               end else if (wait_cnt == WAIT_LAST) begin
                  err_q    <= 1'b1;
                  req_err  <= 1'b1;
                  req_ack  <= grant_mask;
                  lock_vld <= 1'b0;
                  state    <= ARB_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ARB_DONE: begin
               rr_ptr   <= grant_id;
               wait_cnt <= '0;
               state    <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
